// File: rtl/clksel_req_ctrl.sv
// -----------------------------------------------------------------------------
// clksel_req_ctrl
//   Requesting side of the glitch-free CPU clock switcher. Decides when the CPU
//   runs from the divided high-speed clock and when it falls back to the
//   low-speed host clock. Drives the switcher's select and divider inputs and
//   treats the switcher's selected-status outputs as an acknowledge handshake.
//   Host-bus accesses are stalled until the slow clock is confirmed.
//
// Ports
//   clk            fast reference clock, all logic on posedge
//   rst            synchronous active-high reset
//   turbo_en       software enable for high-speed operation
//   host_req       current/next access targets the host bus
//   div_sel_cfg    requested high-speed divider (0=/1, 1=/2, 2=/4, 3=/8)
//   hs_ack_async   switcher hsclk_selected status (asynchronous)
//   ls_ack_async   switcher lsclk_selected status (asynchronous)
//   err_clr        clears timeout_err
//   hsclk_sel      select request to the switcher
//   cpuclk_div_sel divider select to the switcher
//   host_ready     low-speed clock confirmed, host access may proceed
//   switch_busy    a clock switch is in progress
//   timeout_err    sticky acknowledge-timeout flag
// -----------------------------------------------------------------------------
module clksel_req_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       turbo_en,
  input  logic       host_req,
  input  logic [1:0] div_sel_cfg,
  input  logic       hs_ack_async,
  input  logic       ls_ack_async,
  input  logic       err_clr,
  output logic       hsclk_sel,
  output logic [1:0] cpuclk_div_sel,
  output logic       host_ready,
  output logic       switch_busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    LS_RUN = 2'd0,
    TO_HS  = 2'd1,
    HS_RUN = 2'd2,
    TO_LS  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] HOLD_C    = CNT_W'(HOLD_CYCLES);

  logic [SYNC_STAGES-1:0] hs_sync_r;
  logic [SYNC_STAGES-1:0] ls_sync_r;
  logic                   hs_ack_s;
  logic                   ls_ack_s;

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_nx_s;
  logic                   hsclk_sel_r;
  logic                   sel_nx_s;
  logic [1:0]             div_r;
  logic [1:0]             div_nx_s;
  logic                   host_ready_r;
  logic                   switch_busy_r;
  logic                   timeout_err_r;
  logic                   err_nx_s;
  logic                   err_set_s;

  // Acknowledge synchronisers: shift each async status into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      hs_sync_r <= {SYNC_STAGES{1'b0}};
      ls_sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      hs_sync_r <= {hs_sync_r[SYNC_STAGES-2:0], hs_ack_async};
      ls_sync_r <= {ls_sync_r[SYNC_STAGES-2:0], ls_ack_async};
    end
  end

  assign hs_ack_s = hs_sync_r[SYNC_STAGES-1];
  assign ls_ack_s = ls_sync_r[SYNC_STAGES-1];

  // Next-state, counter and output-request decode
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    sel_nx_s   = hsclk_sel_r;
    div_nx_s   = div_r;
    err_set_s  = 1'b0;
    case (state_r)
      LS_RUN: begin
        // The counter holds the remaining low-speed dwell after a return
        if (cnt_r == CNT_ZERO) begin
          if (turbo_en && !host_req) begin
            sel_nx_s   = 1'b1;
            div_nx_s   = div_sel_cfg;
            cnt_nx_s   = CNT_ZERO;
            state_nx_s = TO_HS;
          end else begin
            cnt_nx_s = CNT_ZERO;
          end
        end else begin
          cnt_nx_s = cnt_r - CNT_ONE;
        end
      end
      TO_HS: begin
        // A host_req or turbo drop does not abort; HS_RUN handles the exit
        if (hs_ack_s && !ls_ack_s) begin
          cnt_nx_s   = CNT_ZERO;
          state_nx_s = HS_RUN;
        end else if (cnt_r == TIMEOUT_C) begin
          err_set_s  = 1'b1;
          sel_nx_s   = 1'b0;
          cnt_nx_s   = CNT_ZERO;
          state_nx_s = TO_LS;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      HS_RUN: begin
        if (host_req || !turbo_en) begin
          sel_nx_s   = 1'b0;
          cnt_nx_s   = CNT_ZERO;
          state_nx_s = TO_LS;
        end else begin
          cnt_nx_s = CNT_ZERO;
        end
      end
      TO_LS: begin
        // Only the slow-clock acknowledge (or reset) leaves this state
        if (ls_ack_s && !hs_ack_s) begin
          cnt_nx_s   = HOLD_C;
          state_nx_s = LS_RUN;
        end else if (cnt_r == TIMEOUT_C) begin
          err_set_s = 1'b1;
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        sel_nx_s   = 1'b0;
        cnt_nx_s   = CNT_ZERO;
        state_nx_s = LS_RUN;
      end
    endcase

    // A new timeout wins over a simultaneous clear
    if (err_set_s) begin
      err_nx_s = 1'b1;
    end else if (err_clr) begin
      err_nx_s = 1'b0;
    end else begin
      err_nx_s = timeout_err_r;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= LS_RUN;
      cnt_r         <= CNT_ZERO;
      hsclk_sel_r   <= 1'b0;
      div_r         <= 2'd0;
      host_ready_r  <= 1'b1;
      switch_busy_r <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_nx_s;
      cnt_r         <= cnt_nx_s;
      hsclk_sel_r   <= sel_nx_s;
      div_r         <= div_nx_s;
      host_ready_r  <= (state_nx_s == LS_RUN);
      switch_busy_r <= (state_nx_s == TO_HS) || (state_nx_s == TO_LS);
      timeout_err_r <= err_nx_s;
    end
  end

  assign hsclk_sel      = hsclk_sel_r;
  assign cpuclk_div_sel = div_r;
  assign host_ready     = host_ready_r;
  assign switch_busy    = switch_busy_r;
  assign timeout_err    = timeout_err_r;

endmodule

// File: tb/tb_clksel_req_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clksel_req_ctrl
//   Directed scenarios followed by randomized traffic. Expected outputs come
//   from a behavioural model of the clock-request rules: the acknowledge
//   synchronisers are a delay queue, and the controller is a mode plus a
//   dwell/wait cycle count.
// -----------------------------------------------------------------------------
module tb_clksel_req_ctrl;

  localparam int SYNC = 2;
  localparam int HOLD = 8;
  localparam int TMO  = 255;

  localparam int M_LS   = 0;
  localparam int M_UP   = 1;
  localparam int M_HS   = 2;
  localparam int M_DOWN = 3;

  localparam int O_SEL   = 0;
  localparam int O_BUSY  = 1;
  localparam int O_READY = 2;
  localparam int O_ERR   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       turbo_en;
  logic       host_req;
  logic [1:0] div_sel_cfg;
  logic       hs_a;
  logic       ls_a;
  logic       err_clr;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       host_ready;
  logic       switch_busy;
  logic       timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  // behavioural model state
  int         m_mode;
  int         m_hold;
  int         m_wait;
  logic       m_sel;
  logic [1:0] m_div;
  logic       m_err;
  logic       hs_q[$];
  logic       ls_q[$];

  always #5 clk = ~clk;

  clksel_req_ctrl #(
    .SYNC_STAGES(SYNC),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT    (TMO),
    .CNT_W      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .turbo_en      (turbo_en),
    .host_req      (host_req),
    .div_sel_cfg   (div_sel_cfg),
    .hs_ack_async  (hs_a),
    .ls_ack_async  (ls_a),
    .err_clr       (err_clr),
    .hsclk_sel     (hsclk_sel),
    .cpuclk_div_sel(cpuclk_div_sel),
    .host_ready    (host_ready),
    .switch_busy   (switch_busy),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic hs_seen;
    logic ls_seen;
    logic set_err;
    if (rst) begin
      m_mode = M_LS;
      m_hold = 0;
      m_wait = 0;
      m_sel  = 1'b0;
      m_div  = 2'd0;
      m_err  = 1'b0;
      hs_q.delete();
      ls_q.delete();
      for (int i = 0; i < SYNC; i++) begin
        hs_q.push_back(1'b0);
        ls_q.push_back(1'b0);
      end
    end else begin
      hs_seen = hs_q.pop_front();
      ls_seen = ls_q.pop_front();
      hs_q.push_back(hs_a);
      ls_q.push_back(ls_a);
      set_err = 1'b0;
      case (m_mode)
        M_LS: begin
          if (m_hold == 0 && turbo_en && !host_req) begin
            m_sel  = 1'b1;
            m_div  = div_sel_cfg;
            m_wait = 0;
            m_mode = M_UP;
          end else if (m_hold > 0) begin
            m_hold = m_hold - 1;
          end
        end
        M_UP: begin
          if (hs_seen && !ls_seen) begin
            m_mode = M_HS;
          end else if (m_wait == TMO) begin
            set_err = 1'b1;
            m_sel   = 1'b0;
            m_wait  = 0;
            m_mode  = M_DOWN;
          end else begin
            m_wait = m_wait + 1;
          end
        end
        M_HS: begin
          if (host_req || !turbo_en) begin
            m_sel  = 1'b0;
            m_wait = 0;
            m_mode = M_DOWN;
          end
        end
        default: begin
          if (ls_seen && !hs_seen) begin
            m_hold = HOLD;
            m_mode = M_LS;
          end else if (m_wait == TMO) begin
            set_err = 1'b1;
          end else begin
            m_wait = m_wait + 1;
          end
        end
      endcase
      m_err = set_err ? 1'b1 : (err_clr ? 1'b0 : m_err);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("hsclk_sel", hsclk_sel, m_sel);
    chk("cpuclk_div_sel", cpuclk_div_sel, m_div);
    chk("host_ready", host_ready, m_mode == M_LS);
    chk("switch_busy", switch_busy, (m_mode == M_UP) || (m_mode == M_DOWN));
    chk("timeout_err", timeout_err, m_err);
  endtask

  function automatic logic cur_out(input int which);
    case (which)
      O_SEL:   return hsclk_sel;
      O_BUSY:  return switch_busy;
      O_READY: return host_ready;
      default: return timeout_err;
    endcase
  endfunction

  // Tick until the selected output reaches val or max_n ticks elapse
  task automatic wait_out(input int which, input logic val, input int max_n, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cur_out(which) !== val && n < max_n);
  endtask

  initial begin
    int n;
    rst = 1'b1; turbo_en = 1'b0; host_req = 1'b0; div_sel_cfg = 2'd0;
    hs_a = 1'b0; ls_a = 1'b1; err_clr = 1'b0;
    tick();
    tick();
    chk("rst_ready", host_ready, 1'b1);
    chk("rst_sel", hsclk_sel, 1'b0);
    chk("rst_busy", switch_busy, 1'b0);

    // First high-speed request right after reset
    rst = 1'b0; turbo_en = 1'b1; div_sel_cfg = 2'd2;
    tick();
    chk("req_sel", hsclk_sel, 1'b1);
    chk("req_div", cpuclk_div_sel, 2'd2);
    hs_a = 1'b1; ls_a = 1'b0;
    wait_out(O_BUSY, 1'b0, 10, n);
    chk("hs_busy_len", n, SYNC + 1);
    chk("hs_ready", host_ready, 1'b0);

    // Host access forces return to low speed, then the dwell
    host_req = 1'b1;
    tick();
    chk("drop_sel", hsclk_sel, 1'b0);
    hs_a = 1'b0; ls_a = 1'b1;
    wait_out(O_READY, 1'b1, 10, n);
    chk("ls_ready_lat", n, SYNC + 1);
    host_req = 1'b0;
    wait_out(O_SEL, 1'b1, 20, n);
    chk("hold_len", n, HOLD + 1);
    hs_a = 1'b1; ls_a = 1'b0;
    wait_out(O_BUSY, 1'b0, 10, n);
    chk("hs_again", n, SYNC + 1);

    // Divider config is latched only at high-speed entry
    turbo_en = 1'b0;
    tick();
    hs_a = 1'b0; ls_a = 1'b1;
    wait_out(O_READY, 1'b1, 10, n);
    div_sel_cfg = 2'd3;
    repeat (12) tick();
    chk("cfg_ignored", cpuclk_div_sel, 2'd2);
    turbo_en = 1'b1;
    wait_out(O_SEL, 1'b1, 20, n);
    chk("cfg_taken", cpuclk_div_sel, 2'd3);

    // hs ack never arrives: timeout, with err_clr competing at the set edge
    err_clr = 1'b1;
    wait_out(O_ERR, 1'b1, 400, n);
    chk("tmo_len", n, TMO + 1);
    chk("tmo_sel", hsclk_sel, 1'b0);
    chk("tmo_set_over_clr", timeout_err, 1'b1);
    tick();
    chk("err_clr", timeout_err, 1'b0);
    err_clr = 1'b0;

    // Both acks high is not a completion
    wait_out(O_SEL, 1'b1, 20, n);
    chk("up_again", hsclk_sel, 1'b1);
    host_req = 1'b1; hs_a = 1'b1; ls_a = 1'b1;
    repeat (20) tick();
    chk("both_busy", switch_busy, 1'b1);
    chk("both_sel", hsclk_sel, 1'b1);
    ls_a = 1'b0;
    wait_out(O_BUSY, 1'b0, 10, n);
    chk("hs_after_both", n, SYNC + 1);
    tick();
    chk("exit_sel", hsclk_sel, 1'b0);
    chk("exit_busy", switch_busy, 1'b1);

    // Reset while waiting in the return switch
    rst = 1'b1;
    tick();
    chk("mid_rst_sel", hsclk_sel, 1'b0);
    chk("mid_rst_div", cpuclk_div_sel, 2'd0);
    chk("mid_rst_ready", host_ready, 1'b1);
    chk("mid_rst_busy", switch_busy, 1'b0);
    chk("mid_rst_err", timeout_err, 1'b0);
    rst = 1'b0; host_req = 1'b0; hs_a = 1'b0; ls_a = 1'b1;

    // Randomized traffic with a lazily-responding switcher
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 9) == 0) turbo_en = ~turbo_en;
      if ($urandom_range(0, 7) == 0) host_req = ~host_req;
      div_sel_cfg = 2'($urandom_range(0, 3));
      err_clr = ($urandom_range(0, 19) == 0);
      if (m_sel) begin
        if (ls_a) ls_a = 1'b0;
        else if (!hs_a && $urandom_range(0, 2) == 0) hs_a = 1'b1;
      end else begin
        if (hs_a) hs_a = 1'b0;
        else if (!ls_a && $urandom_range(0, 2) == 0) ls_a = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) begin
        hs_a = 1'b1;
        ls_a = 1'b1;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clksel_req_ctrl.md
Name: clksel_req_ctrl

Overview:
- Requesting side of the glitch-free CPU clock switcher.
- Decides when the CPU runs from the divided high-speed clock and when it runs from the low-speed host clock, then drives the switcher's select and divider inputs.
- Tracks the switcher's selected-status outputs as an acknowledge handshake and stalls host-bus accesses until the slow clock is confirmed.
- Sits in the fast clock domain beside the address decoder.

Parameters:
SYNC_STAGES, 2, flops in each acknowledge synchroniser (minimum 2)
HOLD_CYCLES, 8, minimum clk cycles spent in low-speed mode after each return before a new high-speed request
TIMEOUT, 255, clk cycles to wait for an acknowledge before flagging an error
CNT_W, 8, width of the hold/timeout counter; must hold max(HOLD_CYCLES, TIMEOUT)

Ports:
clk  input  1  free-running high-speed reference clock; all logic on posedge
rst  input  1  synchronous active-high reset
turbo_en  input  1  software enable for high-speed operation
host_req  input  1  current/next CPU access targets the host bus and needs the low-speed clock
div_sel_cfg  input  2  requested high-speed divider: 0=/1, 1=/2, 2=/4, 3=/8
hs_ack_async  input  1  switcher hsclk_selected status, asynchronous
ls_ack_async  input  1  switcher lsclk_selected status, asynchronous
err_clr  input  1  clears timeout_err
hsclk_sel  output  1  select request to the switcher
cpuclk_div_sel  output  2  divider select to the switcher
host_ready  output  1  host access may proceed; low-speed clock confirmed
switch_busy  output  1  a switch is in progress
timeout_err  output  1  sticky acknowledge-timeout flag

Behaviour:
- Reset values (synchronous, wins over everything): hsclk_sel=0, cpuclk_div_sel=0, host_ready=1, switch_busy=0, timeout_err=0, state=LS_RUN, counter=0, synchroniser flops=0.
- Synchronisers: each ack passes through SYNC_STAGES flops. hs_ack and ls_ack below refer to the synchronised values.
- All outputs are registered.
- host_ready=1 only in LS_RUN. switch_busy=1 only in TO_HS or TO_LS.
- States:
  - LS_RUN:
    - Counter decrements to 0 and saturates.
    - If counter==0 and turbo_en=1 and host_req=0: next cycle hsclk_sel=1, cpuclk_div_sel<=div_sel_cfg, counter<=0, go to TO_HS.
    - If host_req and turbo_en are both high, stay in LS_RUN.
  - TO_HS:
    - Counter increments.
    - If hs_ack=1 and ls_ack=0: go to HS_RUN.
    - Else if counter==TIMEOUT: timeout_err<=1, hsclk_sel<=0, counter<=0, go to TO_LS.
    - host_req or a turbo_en drop does NOT abort the switch. The switch completes first, and HS_RUN exits on the following cycle.
  - HS_RUN:
    - If host_req=1 or turbo_en=0: hsclk_sel<=0, counter<=0, go to TO_LS.
  - TO_LS:
    - Counter increments, saturating at TIMEOUT.
    - If ls_ack=1 and hs_ack=0: counter<=HOLD_CYCLES, go to LS_RUN.
    - If counter reaches TIMEOUT: timeout_err<=1 and keep waiting. There is no other exit except reset.
- cpuclk_div_sel changes only on the LS_RUN->TO_HS transition. div_sel_cfg changes at any other time are ignored until the next high-speed entry.
- timeout_err: set has priority over err_clr in the same cycle.
- Both acks high, or both low, is never accepted as completion in either wait state.
- Reset mid-switch returns immediately to LS_RUN with hsclk_sel=0. The switcher's own reset handles clock safety.
- Minimum latency from host_req rising in HS_RUN to host_ready=1 is 1 + SYNC_STAGES + the switcher's turnaround + 1 cycles.

Test Plan:
- Reset, then turbo_en=1, host_req=0, div_sel_cfg=2 → hsclk_sel=1 and cpuclk_div_sel=2 the cycle after reset deasserts. Model acks hs=1/ls=0 → HS_RUN; switch_busy=1 for exactly SYNC_STAGES+1 cycles after the ack change; host_ready stays 0.
- In HS_RUN assert host_req → hsclk_sel=0 next cycle. Ack ls=1/hs=0 → host_ready=1 after 2 sync cycles + 1. turbo_en held high → no re-request for 8 cycles; hsclk_sel rises on cycle 9 after host_req drops.
- In LS_RUN change div_sel_cfg 2→3 with turbo_en=0 → cpuclk_div_sel stays 2; it becomes 3 only on the next LS→HS request.
- hs_ack never arrives → timeout_err=1 at 255 cycles in TO_HS, hsclk_sel=0. Assert err_clr and set in the same cycle → stays 1. err_clr alone → 0.
- In TO_HS, pulse host_req and hold acks both high for 20 cycles → no transition. Then hs=1/ls=0 → HS_RUN, then TO_LS on the next cycle because host_req is still high.
- Assert rst for 1 cycle during TO_LS → all outputs return to reset values on the next edge.
